// File: rtl/seg7_scan_controller_if.sv
// CPU-side register bus for the 7-segment scan controller.
// The decoder/CPU drives the master side and the peripheral answers on the slave side.
interface seg7_scan_controller_if;
  logic        cs;
  logic        rw;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output cs, output rw, output addr, output wdata, input rdata);
  modport slave  (input cs, input rw, input addr, input wdata, output rdata);
endinterface

// File: rtl/seg7_scan_controller.sv
// Bus-mapped 8-digit hex display driver.
// Holds DATA/CTRL registers and time-multiplexes the digits onto common-anode segments.
module seg7_scan_controller #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned NUM_DIGITS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_scan_controller_if.slave bus,
  output logic [7:0]            an,
  output logic [7:0]            seg
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_TC = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [31:0]   data_q;
  logic [7:0]    en_q;
  logic [7:0]    dp_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rd_mux;
  logic [7:0]    an_nxt;
  logic [7:0]    seg_nxt;
  logic          tick;
  logic          wr_en;
  logic          rd_en;
  logic [1:0]    reg_sel;
  logic [1:0]    unused_addr;

  assign tick        = (presc == PRESC_TC);
  assign wr_en       = bus.cs & bus.rw;
  assign rd_en       = bus.cs & ~bus.rw;
  assign reg_sel     = bus.addr[3:2];
  assign unused_addr = bus.addr[1:0];
  assign bus.rdata   = rdata_q;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    rd_mux = 32'h0;
    case (reg_sel)
      2'd0: rd_mux = data_q;
      2'd1: rd_mux = {16'h0, dp_q, en_q};
      2'd2: rd_mux = {{(32-IW){1'b0}}, idx};
      default: rd_mux = 32'h0;
    endcase
  end

  // Output is built from the pre-edge index and registers, so it trails the index by one cycle.
  always_comb begin
    an_nxt  = 8'hFF;
    seg_nxt = 8'hFF;
    if (en_q[idx]) begin
      an_nxt  = ~(8'h01 << idx);
      seg_nxt = {~dp_q[idx], hex7(data_q[{idx, 2'b00} +: 4])};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc   <= '0;
      idx     <= '0;
      data_q  <= 32'h0;
      en_q    <= 8'hFF;
      dp_q    <= 8'h00;
      rdata_q <= 32'h0;
      an      <= 8'hFF;
      seg     <= 8'hFF;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      if (wr_en && reg_sel == 2'd0) begin
        data_q <= bus.wdata;
      end
      if (wr_en && reg_sel == 2'd1) begin
        en_q <= bus.wdata[7:0];
        dp_q <= bus.wdata[15:8];
      end
      if (rd_en) begin
        rdata_q <= rd_mux;
      end
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Self-checking bench: directed scenarios then random bus traffic against a time-based scan model.
module tb_seg7_scan_controller;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] an;
  logic [7:0] seg;

  seg7_scan_controller_if bus_if();

  seg7_scan_controller #(.REFRESH_DIV(DIV), .NUM_DIGITS(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .an    (an),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: registers plus count of clock edges since reset; digit = (edges / DIV) % 8.
  logic [31:0] m_data;
  logic [31:0] m_ctrl;
  logic [31:0] m_rdata;
  logic [7:0]  m_an;
  logic [7:0]  m_seg;
  int          m_t;

  logic [6:0] dec [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_idx();
    return (m_t / DIV) % 8;
  endfunction

  task automatic step(input bit r, input bit c, input bit w, input logic [3:0] a, input logic [31:0] d);
    int i;
    rst_n         = ~r;
    bus_if.cs     = c;
    bus_if.rw     = w;
    bus_if.addr   = a;
    bus_if.wdata  = d;
    @(posedge clk);
    if (r) begin
      m_data  = 32'h0;
      m_ctrl  = 32'hFF;
      m_rdata = 32'h0;
      m_an    = 8'hFF;
      m_seg   = 8'hFF;
      m_t     = 0;
    end else begin
      i = m_idx();
      if (m_ctrl[i]) begin
        m_an  = ~(8'h01 << i);
        m_seg = {~m_ctrl[8+i], dec[m_data[4*i +: 4]]};
      end else begin
        m_an  = 8'hFF;
        m_seg = 8'hFF;
      end
      if (c && !w) begin
        case (a[3:2])
          2'd0: m_rdata = m_data;
          2'd1: m_rdata = m_ctrl;
          2'd2: m_rdata = i;
          default: m_rdata = 32'h0;
        endcase
      end
      if (c && w) begin
        if (a[3:2] == 2'd0) m_data = d;
        if (a[3:2] == 2'd1) m_ctrl = {16'h0, d[15:0]};
      end
      m_t++;
    end
    @(negedge clk);
    check_val("an", {24'h0, an}, {24'h0, m_an});
    check_val("seg", {24'h0, seg}, {24'h0, m_seg});
    check_val("rdata", bus_if.rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    int j;
    bit found;
    bus_if.cs = 1'b0; bus_if.rw = 1'b0; bus_if.addr = 4'h0; bus_if.wdata = 32'h0;
    rst_n = 1'b0;

    // reset held three cycles
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    check_val("rst_an", {24'h0, an}, 32'hFF);
    check_val("rst_seg", {24'h0, seg}, 32'hFF);
    check_val("rst_rdata", bus_if.rdata, 32'h0);
    idle(1);
    check_val("rel_an", {24'h0, an}, 32'hFE);
    check_val("rel_seg", {24'h0, seg}, 32'hC0);

    // data scan
    step(1'b0, 1'b1, 1'b1, 4'h0, 32'h8765_4321);
    idle(40);

    // ctrl enables/dp
    step(1'b0, 1'b1, 1'b1, 4'h4, 32'h0000_0105);
    idle(40);

    // readback
    step(1'b0, 1'b1, 1'b1, 4'h0, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
    check_val("rd_data", bus_if.rdata, 32'hDEAD_BEEF);
    step(1'b0, 1'b1, 1'b1, 4'h4, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 1'b0, 4'h4, 32'h0);
    check_val("rd_ctrl", bus_if.rdata, 32'h0000_FFFF);
    step(1'b0, 1'b1, 1'b0, 4'h8, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'hC, 32'h0);
    check_val("rd_rsvd", bus_if.rdata, 32'h0);
    idle(3);
    check_val("rd_hold", bus_if.rdata, 32'h0);

    // write landing on the tick edge
    found = 1'b0;
    for (int k = 0; k < 2 * DIV && !found; k++) begin
      if (m_t % DIV == DIV - 1) found = 1'b1;
      else idle(1);
    end
    check_val("wait_tick", {31'h0, found}, 32'h1);
    v = $urandom;
    step(1'b0, 1'b1, 1'b1, 4'h0, v);
    j = m_idx();
    idle(1);
    check_val("tick_wr", {25'h0, seg[6:0]}, {25'h0, dec[v[4*j +: 4]]});

    // mid-scan reset at digit 5
    found = 1'b0;
    for (int k = 0; k < 8 * DIV + 2 && !found; k++) begin
      if (m_idx() == 5 && (m_t % DIV) == 1) found = 1'b1;
      else idle(1);
    end
    check_val("wait_d5", {31'h0, found}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    check_val("mid_rst_an", {24'h0, an}, 32'hFF);
    step(1'b0, 1'b0, 1'b1, 4'h0, 32'h1234_5678);
    check_val("restart_an", {24'h0, an}, 32'hFE);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0);
    check_val("mid_rst_data", bus_if.rdata, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'h4, 32'h0);
    check_val("mid_rst_ctrl", bus_if.rdata, 32'hFF);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 249) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_controller.md
Name: seg7_scan_controller

Overview:
- Bus-mapped peripheral downstream of the address decoder. It is the slave behind decoder select bit 1 (7-segment display, CPU base 0xFFFF_FF10).
- Latches CPU writes into data and control registers and returns register contents on reads.
- Time-multiplexes 8 hex digits onto a common-anode 7-segment display using a prescaled scan counter.
- Anode and segment outputs are registered.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; legal range 2..2^20.
- NUM_DIGITS, 8, number of digits scanned; fixed at 8 in this revision.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- cs  input  1  chip select, driven by decoder select[1].
- rw  input  1  1 = write, 0 = read; qualified by cs.
- addr  input  4  byte offset within the window; addr[3:2] selects the register, addr[1:0] is ignored.
- wdata  input  32  write data.
- rdata  output  32  read data, registered.
- an  output  8  digit anodes, active low; bit i = digit i.
- seg  output  8  {dp, g, f, e, d, c, b, a}, active low.

Behaviour:
- Reset and clock: only rst_n low at a posedge clk resets the block. There is no asynchronous path.
- Reset values:
  - DATA = 0
  - CTRL = 0x0000_00FF (all digits enabled, all dp off)
  - prescaler = 0, digit index = 0
  - an = 8'hFF, seg = 8'hFF, rdata = 0
- Register map (addr[3:2]):
  - 0 DATA: RW, 32 bits. Digit i shows nibble DATA[4i+3:4i].
  - 1 CTRL: RW. [7:0] digit enable, [15:8] dp on per digit. Bits [31:16] read 0; writes to them are ignored.
  - 2 STATUS: RO. [2:0] current digit index, other bits 0. Writes are ignored.
  - 3: reads 0; writes are ignored.
- Write:
  - When cs & rw at posedge clk, the selected register is updated at that edge.
  - The new value appears on an/seg no later than the next digit-slot boundary plus 1 cycle.
- Read:
  - When cs & ~rw at posedge clk, rdata is loaded with the selected register at that edge (1-cycle latency).
  - rdata holds its value until the next read.
  - When cs = 0, rdata holds.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. The terminal count (REFRESH_DIV-1) produces a 1-cycle tick.
- Digit index: increments on tick and wraps 7 -> 0.
- Output register, updated every cycle from the current index i:
  - If CTRL[i] = 1: an = ~(1 << i), seg[6:0] = decode(DATA nibble i), seg[7] = ~CTRL[8+i].
  - If CTRL[i] = 0: an = 8'hFF, seg = 8'hFF.
  - Output lags the index by 1 cycle.
- Decode table, g..a, active low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Exactly one anode is low at any time, or none when the current digit is disabled.
- Simultaneous write and tick: the register update and the index advance both take effect at that edge. The output after the edge uses the new register value and the new index.
- Reset mid-scan: prescaler, index and outputs return to reset values at the edge. Register contents are lost.

Test Plan (REFRESH_DIV = 4):
1. Reset: hold rst_n = 0 for 3 cycles, then release -> an = FF and seg = FF during reset; rdata = 0; first cycle after release: an = FE, seg = 0xC0 (digit 0, value 0, dp off).
2. Write DATA = 0x8765_4321 -> an steps FE, FD, FB, ..., 7F, changing every 4 cycles. seg[6:0] for digits 0..3 = 1111001, 0100100, 0110000, 0011001. an returns to FE after 32 cycles.
3. Write CTRL = 0x0000_0105 -> digit 0 shows with seg[7] = 0 (dp on); digit 2 shows with dp off; during digits 1 and 3-7, an = FF and seg = FF.
4. Read back: write DATA = 0xDEAD_BEEF, then read addr 0 -> rdata = DEADBEEF one cycle later. Read addr 4 after writing 0xFFFF_FFFF -> rdata = 0x0000_FFFF. Read addr 8 -> index in [2:0]. Read addr C -> 0.
5. Write on tick edge: issue a DATA write in the same cycle as the prescaler terminal count -> the next output already shows the new nibble for the next digit.
6. Mid-scan reset at digit 5: pulse rst_n low for 1 cycle -> an = FF; DATA and CTRL return to reset values (CTRL = 0xFF, DATA = 0); scan restarts at digit 0; cs = 0 writes have no effect.
